// File: rtl/keccak_pkg.sv
// Shared constants, state/mode encodings and rate helpers for the multi-rate Keccak padder.
package keccak_pkg;

    localparam int MAX_RATE  = 1152;
    localparam int RATE_1152 = 1152;
    localparam int RATE_1088 = 1088;
    localparam int RATE_832  = 832;
    localparam int RATE_576  = 576;

    localparam logic [7:0] FINAL_PAD = 8'h80;

    typedef enum logic [1:0] {
        MODE_1152 = 2'd0,
        MODE_1088 = 2'd1,
        MODE_832  = 2'd2,
        MODE_576  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ABSORB    = 2'd1,
        FULL      = 2'd2,
        FULL_LAST = 2'd3
    } state_e;

    function automatic int rate_bits(input logic [1:0] mode);
        case (mode_e'(mode))
            MODE_1152: return RATE_1152;
            MODE_1088: return RATE_1088;
            MODE_832:  return RATE_832;
            MODE_576:  return RATE_576;
            default:   return RATE_1152;
        endcase
    endfunction

    function automatic logic [5:0] rate_words(input logic [1:0] mode, input int width);
        return 6'(rate_bits(mode) / width);
    endfunction

endpackage

// File: rtl/keccak_pad_word.sv
// Combinational padder for one message word: keeps valid bytes, inserts the domain pad
// byte, zeroes the tail and sets the final 0x80 bit when the word closes the block.
module keccak_pad_word
    import keccak_pkg::*;
#(
    parameter int         IN_WIDTH = 64,
    parameter logic [7:0] PAD_BYTE = 8'h01
) (
    input  logic [IN_WIDTH-1:0]           in,
    input  logic [$clog2(IN_WIDTH/8)-1:0] byte_num,
    input  logic                          is_last,
    input  logic                          is_block_end,
    output logic [IN_WIDTH-1:0]           padded
);

    localparam int NB = IN_WIDTH / 8;
    localparam int BW = $clog2(NB);

    // Byte 0 is the most significant byte of the word.
    for (genvar gi = 0; gi < NB; gi++) begin : g_byte
        localparam logic [BW-1:0] IDX = BW'(gi);
        localparam logic [BW-1:0] LAST_IDX = BW'(NB - 1);
        logic [7:0] src;
        logic [7:0] pad;

        assign src = in[IN_WIDTH-1-8*gi -: 8];

        always_comb begin
            pad = src;
            if (is_last) begin
                if (IDX == byte_num) begin
                    pad = PAD_BYTE;
                end else if (IDX > byte_num) begin
                    pad = 8'h00;
                end
                if (is_block_end && (IDX == LAST_IDX)) begin
                    pad = pad | FINAL_PAD;
                end
            end
        end

        assign padded[IN_WIDTH-1-8*gi -: 8] = pad;
    end

endmodule

// File: rtl/keccak_padder_multi.sv
// Multi-rate Keccak input buffer: packs message words into a left-aligned rate block,
// pads the final word and hands each complete block to the core with an ack handshake.
module keccak_padder_multi
    import keccak_pkg::*;
#(
    parameter int         IN_WIDTH = 64,
    parameter logic [7:0] PAD_BYTE = 8'h01
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    mode,
    input  logic [IN_WIDTH-1:0]           in,
    input  logic                          in_ready,
    input  logic                          is_last,
    input  logic [$clog2(IN_WIDTH/8)-1:0] byte_num,
    input  logic                          f_ack,
    output logic                          buffer_full,
    output logic [MAX_RATE-1:0]           out,
    output logic                          out_ready,
    output logic                          out_last,
    output logic [5:0]                    rate_words
);

    localparam int MAX_WORDS = MAX_RATE / IN_WIDTH;
    localparam logic [IN_WIDTH-1:0] FINAL_WORD = {{(IN_WIDTH-8){1'b0}}, FINAL_PAD};

    state_e                state_reg, state_next;
    logic [5:0]            cnt_reg, cnt_next;
    logic [5:0]            rate_reg, rate_next;
    logic [5:0]            cur_rate;
    logic                  accept;
    logic                  clear;
    logic                  block_end;
    logic [IN_WIDTH-1:0]   padded;
    logic [MAX_RATE-1:0]   block_reg, block_next;

    // The first word of a message uses the rate selected on that same cycle.
    always_comb begin
        cur_rate   = (state_reg == IDLE) ? keccak_pkg::rate_words(mode, IN_WIDTH) : rate_reg;
        block_end  = (cnt_reg == cur_rate - 6'd1);
        accept     = in_ready && ((state_reg == IDLE) || (state_reg == ABSORB));
        clear      = f_ack && ((state_reg == FULL) || (state_reg == FULL_LAST));
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rate_next  = rate_reg;
        case (state_reg)
            IDLE, ABSORB: begin
                if (accept) begin
                    if (state_reg == IDLE) begin
                        rate_next = cur_rate;
                    end
                    if (is_last) begin
                        state_next = FULL_LAST;
                        cnt_next   = 6'd0;
                    end else if (block_end) begin
                        state_next = FULL;
                        cnt_next   = 6'd0;
                    end else begin
                        state_next = ABSORB;
                        cnt_next   = cnt_reg + 6'd1;
                    end
                end
            end
            FULL: begin
                if (f_ack) begin
                    state_next = ABSORB;
                end
            end
            FULL_LAST: begin
                if (f_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    keccak_pad_word #(
        .IN_WIDTH (IN_WIDTH),
        .PAD_BYTE (PAD_BYTE)
    ) u_pad (
        .in           (in),
        .byte_num     (byte_num),
        .is_last      (is_last),
        .is_block_end (block_end),
        .padded       (padded)
    );

    // Per-word write enables; a last word also zero-fills the rest of the block in the same cycle.
    for (genvar gi = 0; gi < MAX_WORDS; gi++) begin : g_word
        localparam logic [5:0] IDX = 6'(gi);
        localparam int         HI  = MAX_RATE - 1 - gi * IN_WIDTH;
        logic [IN_WIDTH-1:0] word;

        always_comb begin
            word = block_reg[HI -: IN_WIDTH];
            if (clear) begin
                word = '0;
            end else if (accept) begin
                if (IDX == cnt_reg) begin
                    word = padded;
                end else if (is_last && (IDX > cnt_reg)) begin
                    word = (IDX == cur_rate - 6'd1) ? FINAL_WORD : '0;
                end
            end
        end

        assign block_next[HI -: IN_WIDTH] = word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 6'd0;
            rate_reg  <= keccak_pkg::rate_words(2'd0, IN_WIDTH);
            block_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rate_reg  <= rate_next;
            block_reg <= block_next;
        end
    end

    assign out_ready   = (state_reg == FULL) || (state_reg == FULL_LAST);
    assign out_last    = (state_reg == FULL_LAST);
    assign buffer_full = out_ready;
    assign out         = block_reg;
    assign rate_words  = rate_reg;

endmodule
